// File: rtl/slot_io_decoder.sv
// Apple II peripheral-slot address decoder: registered DEVSEL/IOSEL/IOSTROBE pulses,
// $C800 expansion-ROM ownership tracking and an in-order capture FIFO for DEVSEL writes.
module slot_io_decoder #(
  parameter int SLOT       = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int PW        = $clog2(FIFO_DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic          clk_logic_i,
  input  logic          reset_i,
  input  logic          device_reset_n_i,
  input  logic [15:0]   addr_i,
  input  logic [7:0]    data_i,
  input  logic          rw_n_i,
  input  logic          data_in_strobe_i,
  output logic          devsel_o,
  output logic          iosel_o,
  output logic          iostrobe_o,
  output logic          c8_sel_o,
  output logic          c8_owner_o,
  output logic [10:0]   sel_addr_o,
  output logic          sel_rw_n_o,
  output logic          wr_valid_o,
  input  logic          wr_ready_i,
  output logic [3:0]    wr_reg_o,
  output logic [7:0]    wr_data_o,
  output logic [CW-1:0] fifo_count_o,
  output logic          overflow_o
);

  localparam logic [2:0] SLOT_L = 3'(SLOT);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} own_state_t;

  own_state_t   state_q, state_d;
  logic         devsel_q, iosel_q, iostrobe_q, c8_sel_q;
  logic [10:0]  sel_addr_q;
  logic         sel_rw_n_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic         overflow_q;
  logic [11:0]  mem_q [FIFO_DEPTH];

  logic dev_hit, io_hit, strb_hit, cfff_hit;
  logic push, pop, full, accept, drop;

  always_comb begin
    dev_hit  = data_in_strobe_i && (addr_i[15:7] == 9'h181) && (addr_i[6:4] == SLOT_L);
    io_hit   = data_in_strobe_i && (addr_i[15:8] == {5'b11000, SLOT_L});
    strb_hit = data_in_strobe_i && (addr_i[15:11] == 5'b11001);
    cfff_hit = data_in_strobe_i && (addr_i == 16'hCFFF);
    push     = dev_hit && !rw_n_i && device_reset_n_i;
    pop      = (count_q != {CW{1'b0}}) && wr_ready_i;
    full     = (count_q == CW'(FIFO_DEPTH));
    accept   = push && (!full || pop);
    drop     = push && full && !pop;
    if (accept && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!accept && pop) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Ownership is released by any $CFFF access and claimed by this slot's IOSEL page.
  always_comb begin
    state_d = state_q;
    if (!device_reset_n_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (io_hit) state_d = OWNED; else state_d = IDLE;
        OWNED:   if (cfff_hit) state_d = IDLE; else state_d = OWNED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_logic_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      devsel_q   <= 1'b0;
      iosel_q    <= 1'b0;
      iostrobe_q <= 1'b0;
      c8_sel_q   <= 1'b0;
      sel_addr_q <= 11'd0;
      sel_rw_n_q <= 1'b1;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      devsel_q   <= dev_hit;
      iosel_q    <= io_hit;
      iostrobe_q <= strb_hit;
      // c8_sel looks at ownership as it stood before this access.
      c8_sel_q   <= strb_hit && (state_q == OWNED);
      if (dev_hit || io_hit || strb_hit) begin
        sel_addr_q <= addr_i[10:0];
        sel_rw_n_q <= rw_n_i;
      end
      if (!device_reset_n_i) begin
        wr_ptr_q <= {PW{1'b0}};
        rd_ptr_q <= {PW{1'b0}};
        count_q  <= {CW{1'b0}};
      end else begin
        if (accept) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_d;
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_logic_i) begin
    if (accept) mem_q[wr_ptr_q] <= {addr_i[3:0], data_i};
  end

  assign devsel_o     = devsel_q;
  assign iosel_o      = iosel_q;
  assign iostrobe_o   = iostrobe_q;
  assign c8_sel_o     = c8_sel_q;
  assign c8_owner_o   = (state_q == OWNED);
  assign sel_addr_o   = sel_addr_q;
  assign sel_rw_n_o   = sel_rw_n_q;
  assign wr_valid_o   = (count_q != {CW{1'b0}});
  assign wr_reg_o     = mem_q[rd_ptr_q][11:8];
  assign wr_data_o    = mem_q[rd_ptr_q][7:0];
  assign fifo_count_o = count_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_slot_io_decoder.sv
// Directed bench for slot_io_decoder (SLOT=3, FIFO_DEPTH=4): inputs change and outputs
// are checked on the falling edge, so each check sees the state after the last rising edge.
module tb_slot_io_decoder;

  logic        clk_logic_i = 1'b0;
  logic        reset_i, device_reset_n_i;
  logic [15:0] addr_i;
  logic [7:0]  data_i;
  logic        rw_n_i, data_in_strobe_i, wr_ready_i;
  logic        devsel_o, iosel_o, iostrobe_o, c8_sel_o, c8_owner_o;
  logic [10:0] sel_addr_o;
  logic        sel_rw_n_o, wr_valid_o, overflow_o;
  logic [3:0]  wr_reg_o;
  logic [7:0]  wr_data_o;
  logic [2:0]  fifo_count_o;

  int n_cmp = 0;
  int n_err = 0;

  slot_io_decoder #(.SLOT(3), .FIFO_DEPTH(4)) dut (
    .clk_logic_i(clk_logic_i), .reset_i(reset_i), .device_reset_n_i(device_reset_n_i),
    .addr_i(addr_i), .data_i(data_i), .rw_n_i(rw_n_i), .data_in_strobe_i(data_in_strobe_i),
    .devsel_o(devsel_o), .iosel_o(iosel_o), .iostrobe_o(iostrobe_o), .c8_sel_o(c8_sel_o),
    .c8_owner_o(c8_owner_o), .sel_addr_o(sel_addr_o), .sel_rw_n_o(sel_rw_n_o),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_reg_o(wr_reg_o),
    .wr_data_o(wr_data_o), .fifo_count_o(fifo_count_o), .overflow_o(overflow_o)
  );

  always #5 clk_logic_i = ~clk_logic_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge of cycle N+1.
  task automatic do_strobe(input logic [15:0] a, input logic rw, input logic [7:0] d);
    addr_i = a; rw_n_i = rw; data_i = d; data_in_strobe_i = 1'b1;
    @(negedge clk_logic_i);
    data_in_strobe_i = 1'b0;
  endtask

  task automatic pulses(input string tag, input logic dv, input logic io, input logic st,
                        input logic c8);
    chk({tag, ".devsel"},   32'(devsel_o),   32'(dv));
    chk({tag, ".iosel"},    32'(iosel_o),    32'(io));
    chk({tag, ".iostrobe"}, 32'(iostrobe_o), 32'(st));
    chk({tag, ".c8_sel"},   32'(c8_sel_o),   32'(c8));
  endtask

  initial begin
    reset_i = 1'b1; device_reset_n_i = 1'b1; addr_i = 16'h0000; data_i = 8'h00;
    rw_n_i = 1'b1; data_in_strobe_i = 1'b0; wr_ready_i = 1'b0;
    repeat (2) @(negedge clk_logic_i);
    // Reset must dominate a concurrent devsel write.
    do_strobe(16'hC0B5, 1'b0, 8'hA5);
    reset_i = 1'b0;
    pulses("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.owner", 32'(c8_owner_o), 32'd0);
    chk("rst.count", 32'(fifo_count_o), 32'd0);
    chk("rst.valid", 32'(wr_valid_o), 32'd0);
    chk("rst.ovf", 32'(overflow_o), 32'd0);
    chk("rst.sel_addr", 32'(sel_addr_o), 32'h000);
    chk("rst.sel_rw", 32'(sel_rw_n_o), 32'd1);

    // Basic devsel write
    do_strobe(16'hC0B5, 1'b0, 8'hA5);
    pulses("wr", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wr.valid", 32'(wr_valid_o), 32'd1);
    chk("wr.reg", 32'(wr_reg_o), 32'h5);
    chk("wr.data", 32'(wr_data_o), 32'hA5);
    chk("wr.count", 32'(fifo_count_o), 32'd1);
    chk("wr.sel_addr", 32'(sel_addr_o), 32'h0B5);
    chk("wr.sel_rw", 32'(sel_rw_n_o), 32'd0);
    @(negedge clk_logic_i);
    chk("wr.pulse_end", 32'(devsel_o), 32'd0);
    chk("wr.hold", 32'(wr_data_o), 32'hA5);
    wr_ready_i = 1'b1;
    @(negedge clk_logic_i);
    chk("pop.count", 32'(fifo_count_o), 32'd0);
    @(negedge clk_logic_i);
    wr_ready_i = 1'b0;
    chk("pop_empty.count", 32'(fifo_count_o), 32'd0);

    // Devsel read never pushes; other slots' addresses don't decode
    do_strobe(16'hC0B0, 1'b1, 8'h00);
    pulses("rd", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rd.count", 32'(fifo_count_o), 32'd0);
    chk("rd.sel_addr", 32'(sel_addr_o), 32'h0B0);
    do_strobe(16'hC0A3, 1'b0, 8'h11);
    pulses("slot2", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("slot2.count", 32'(fifo_count_o), 32'd0);
    chk("slot2.sel_hold", 32'(sel_addr_o), 32'h0B0);
    do_strobe(16'hC400, 1'b1, 8'h00);
    pulses("slot4io", 1'b0, 1'b0, 1'b0, 1'b0);

    // Expansion ROM ownership sequence
    do_strobe(16'hC300, 1'b1, 8'h00);
    pulses("own1", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("own1.owner", 32'(c8_owner_o), 32'd1);
    chk("own1.sel_addr", 32'(sel_addr_o), 32'h300);
    do_strobe(16'hC812, 1'b1, 8'h00);
    pulses("own2", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("own2.owner", 32'(c8_owner_o), 32'd1);
    chk("own2.sel_addr", 32'(sel_addr_o), 32'h012);
    do_strobe(16'hCFFF, 1'b1, 8'h00);
    pulses("own3", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("own3.owner", 32'(c8_owner_o), 32'd0);
    chk("own3.sel_addr", 32'(sel_addr_o), 32'h7FF);
    do_strobe(16'hC812, 1'b1, 8'h00);
    pulses("own4", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("own4.owner", 32'(c8_owner_o), 32'd0);
    do_strobe(16'hCFFF, 1'b0, 8'h00);
    pulses("idle_cfff", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("idle_cfff.owner", 32'(c8_owner_o), 32'd0);

    // Overflow: five writes into a depth-4 FIFO
    for (int i = 0; i < 5; i++) do_strobe(16'(16'hC0B0 + i), 1'b0, 8'(i + 1));
    chk("ovf.count", 32'(fifo_count_o), 32'd4);
    chk("ovf.flag", 32'(overflow_o), 32'd1);
    @(negedge clk_logic_i);
    chk("ovf.head_hold", 32'(wr_data_o), 32'h01);
    wr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf.drain_data", 32'(wr_data_o), 32'(i + 1));
      chk("ovf.drain_reg", 32'(wr_reg_o), 32'(i));
      chk("ovf.drain_count", 32'(fifo_count_o), 32'(4 - i));
      @(negedge clk_logic_i);
    end
    wr_ready_i = 1'b0;
    chk("ovf.empty", 32'(wr_valid_o), 32'd0);
    chk("ovf.sticky", 32'(overflow_o), 32'd1);

    // Device reset: drops ownership and queue, keeps overflow and sel_*
    do_strobe(16'hC300, 1'b1, 8'h00);
    do_strobe(16'hC0B1, 1'b0, 8'h21);
    do_strobe(16'hC0B2, 1'b0, 8'h22);
    chk("dr.pre_owner", 32'(c8_owner_o), 32'd1);
    chk("dr.pre_count", 32'(fifo_count_o), 32'd2);
    device_reset_n_i = 1'b0;
    @(negedge clk_logic_i);
    device_reset_n_i = 1'b1;
    chk("dr.owner", 32'(c8_owner_o), 32'd0);
    chk("dr.count", 32'(fifo_count_o), 32'd0);
    chk("dr.valid", 32'(wr_valid_o), 32'd0);
    chk("dr.ovf", 32'(overflow_o), 32'd1);
    chk("dr.sel_addr", 32'(sel_addr_o), 32'h0B2);
    chk("dr.sel_rw", 32'(sel_rw_n_o), 32'd0);
    device_reset_n_i = 1'b0;
    do_strobe(16'hC0B7, 1'b0, 8'h33);
    chk("dr_wr.devsel", 32'(devsel_o), 32'd1);
    chk("dr_wr.count", 32'(fifo_count_o), 32'd0);
    do_strobe(16'hC300, 1'b1, 8'h00);
    device_reset_n_i = 1'b1;
    chk("dr_io.iosel", 32'(iosel_o), 32'd1);
    chk("dr_io.owner", 32'(c8_owner_o), 32'd0);

    // Same scenario with reset_i additionally clears overflow and sel_*
    do_strobe(16'hC300, 1'b1, 8'h00);
    do_strobe(16'hC0B1, 1'b0, 8'h21);
    do_strobe(16'hC0B2, 1'b0, 8'h22);
    reset_i = 1'b1;
    @(negedge clk_logic_i);
    reset_i = 1'b0;
    chk("hr.owner", 32'(c8_owner_o), 32'd0);
    chk("hr.count", 32'(fifo_count_o), 32'd0);
    chk("hr.valid", 32'(wr_valid_o), 32'd0);
    chk("hr.ovf", 32'(overflow_o), 32'd0);
    chk("hr.sel_addr", 32'(sel_addr_o), 32'h000);
    chk("hr.sel_rw", 32'(sel_rw_n_o), 32'd1);

    // Full FIFO: push and pop in the same cycle
    for (int i = 0; i < 4; i++) do_strobe(16'(16'hC0B0 + i), 1'b0, 8'(8'h10 + i));
    chk("fpp.pre_count", 32'(fifo_count_o), 32'd4);
    wr_ready_i = 1'b1;
    do_strobe(16'hC0BF, 1'b0, 8'h14);
    wr_ready_i = 1'b0;
    chk("fpp.count", 32'(fifo_count_o), 32'd4);
    chk("fpp.ovf", 32'(overflow_o), 32'd0);
    wr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fpp.drain_data", 32'(wr_data_o), 32'(8'h11 + i));
      chk("fpp.drain_reg", 32'(wr_reg_o), (i == 3) ? 32'hF : 32'(i + 1));
      @(negedge clk_logic_i);
    end
    wr_ready_i = 1'b0;
    chk("fpp.empty", 32'(fifo_count_o), 32'd0);

    // Empty FIFO: push and pop in the same cycle, no bypass
    wr_ready_i = 1'b1;
    do_strobe(16'hC0B9, 1'b0, 8'h77);
    wr_ready_i = 1'b0;
    chk("epp.count", 32'(fifo_count_o), 32'd1);
    chk("epp.data", 32'(wr_data_o), 32'h77);
    chk("epp.reg", 32'(wr_reg_o), 32'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/slot_io_decoder.md
SLOT_IO_DECODER -- requirements
Module: slot_io_decoder

Interface
REQ-001 Parameter SLOT, default 3, peripheral slot number 1..7.
REQ-002 Parameter FIFO_DEPTH, default 4, write-capture FIFO entries (power of two, 2..16).
REQ-003 clk_logic_i  in  1  logic clock (54 MHz); all state on its rising edge.
REQ-004 reset_i  in  1  reset; synchronous, active-high.
REQ-005 device_reset_n_i  in  1  Apple bus reset, active-low, sampled synchronously.
REQ-006 addr_i  in  16  latched bus address, stable whenever data_in_strobe_i is high.
REQ-007 data_i  in  8  latched bus data, valid on write cycles when data_in_strobe_i is high.
REQ-008 rw_n_i  in  1  latched bus R/W (1=read).
REQ-009 data_in_strobe_i  in  1  one-cycle pulse, once per 6502 cycle, marks addr/data/rw valid.
REQ-010 devsel_o  out  1  one-cycle pulse: access to $C080+SLOT*16..+$F.
REQ-011 iosel_o  out  1  one-cycle pulse: access to $Cn00-$CnFF (n=SLOT).
REQ-012 iostrobe_o  out  1  one-cycle pulse: access to $C800-$CFFF.
REQ-013 c8_sel_o  out  1  one-cycle pulse: $C800-$CFFF access while this slot owns expansion ROM.
REQ-014 c8_owner_o  out  1  level: this slot owns $C800-$CFFF.
REQ-015 sel_addr_o  out  11  addr_i[10:0] captured with the pulses.
REQ-016 sel_rw_n_o  out  1  rw_n_i captured with the pulses.
REQ-017 wr_valid_o  out  1  FIFO head valid.
REQ-018 wr_ready_i  in  1  consumer pops head when wr_valid_o && wr_ready_i.
REQ-019 wr_reg_o  out  4  head entry register offset (addr[3:0]).
REQ-020 wr_data_o  out  8  head entry data.
REQ-021 fifo_count_o  out  $clog2(FIFO_DEPTH)+1  occupancy.
REQ-022 overflow_o  out  1  sticky: a push was dropped.

Function
REQ-023 Decode is evaluated only in cycle N where data_in_strobe_i=1; all decode pulses are registered and high in cycle N+1 only.
REQ-024 devsel: addr_i[15:7]=9'h181 and addr_i[6:4]=SLOT; iosel: addr_i[15:8]={5'b11000,SLOT[2:0]}; iostrobe: addr_i[15:11]=5'b11001.
REQ-025 sel_addr_o/sel_rw_n_o update only when any decode pulse fires; otherwise hold.
REQ-026 Ownership FSM, states IDLE (c8_owner_o=0) and OWNED (1): IDLE->OWNED on iosel access (read or write); OWNED->IDLE on any access to $CFFF; other accesses hold state.
REQ-027 c8_sel_o uses ownership before the update of the same access; a $CFFF access while OWNED yields c8_sel_o=1 in N+1 and c8_owner_o=0 from N+1.
REQ-028 A $CFFF access with IDLE gives iostrobe_o only, state stays IDLE.
REQ-029 Every devsel write (rw_n_i=0) pushes {addr_i[3:0],data_i} at the end of cycle N; entry visible (wr_valid_o=1 if previously empty) in N+1; devsel reads never push.
REQ-030 FIFO is first-word-fall-through, in order; wr_reg_o/wr_data_o hold head while wr_valid_o=1 and wr_ready_i=0.
REQ-031 Push when full and no pop in same cycle: entry dropped, FIFO unchanged, overflow_o=1 from next cycle.
REQ-032 Simultaneous push and pop when full: pop frees a slot, push accepted, count unchanged, no overflow.
REQ-033 Simultaneous push and pop when empty: push accepted, count becomes 1 (no bypass).
REQ-034 Pop when empty is ignored; count never underflows; pointers wrap modulo FIFO_DEPTH.
REQ-035 fifo_count_o reflects state after each edge; wr_valid_o = (count != 0).

Reset
REQ-036 reset_i=1: all pulses 0, c8_owner_o=0, FIFO empty, count 0, overflow_o=0, sel_addr_o=0, sel_rw_n_o=1; takes effect at next edge, mid-operation included; reset dominates any concurrent strobe.
REQ-037 device_reset_n_i=0: forces ownership IDLE and flushes FIFO (count 0); overflow_o and sel_* unchanged; a strobe in the same cycle produces its pulses but no push and no ownership set.

Verification
REQ-038 SLOT=3, strobe addr $C0B5 rw=0 data $A5 -> devsel_o pulse N+1, wr_valid_o=1, wr_reg_o=5, wr_data_o=$A5, count 1.
REQ-039 strobe read $C300 then read $C812 then read $CFFF then read $C812 -> c8_owner_o 1 after first; c8_sel_o pulses for $C812 and $CFFF; owner 0 after $CFFF; last gives iostrobe_o only.
REQ-040 wr_ready_i=0, five devsel writes data $01..$05 (depth 4) -> count 4, overflow_o=1, then draining yields $01..$04 only.
REQ-041 FIFO full, push in same cycle as pop -> count stays 4, overflow_o stays 0, new entry appears last.
REQ-042 owner set, 2 entries queued, device_reset_n_i=0 one cycle -> c8_owner_o=0, count 0, wr_valid_o=0; reset_i same scenario additionally clears overflow_o.
